// File: rtl/bp_me_wormhole_stream_tx.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_stream_tx
//
// Transmit side of the wormhole stream protocol. One wide packet header and
// N data beats are turned into a bsg_wormhole flit stream: hdr_len_p header
// flits (flit 0 first) followed by N data flits, where
//   N = len - hdr_len_p + 1
// and len is the wormhole length field (number of flits minus one) taken
// from header flit 0.
//
// Ports
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   hdr_i             full header, flit 0 in the LSBs; cord in
//                     [cord_width_p-1:0], len in [cord_width_p +: len_width_p]
//   hdr_v_i           header valid
//   hdr_ready_and_o   header accepted when hdr_v_i & hdr_ready_and_o
//   data_i / data_v_i data beat and its valid
//   data_ready_and_o  beat accepted when data_v_i & data_ready_and_o
//   link_data_o       outgoing flit
//   link_v_o          outgoing flit valid
//   link_ready_and_i  flit accepted when link_v_o & link_ready_and_i
//   link_last_o       current flit is the final flit of its packet
//
// Build option
//   BP_ME_WORMHOLE_TX_HDR_BYPASS_EN : header flit 0 goes straight to the link
//   in the same cycle the header is accepted (no bubble between packets).
//   When undefined, the header is always registered first and its first
//   flit appears the cycle after acceptance.
// ---------------------------------------------------------------------------
module bp_me_wormhole_stream_tx #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    parameter int hdr_len_p    = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [hdr_len_p*flit_width_p-1:0] hdr_i,
    input  logic                              hdr_v_i,
    output logic                              hdr_ready_and_o,

    input  logic [flit_width_p-1:0]           data_i,
    input  logic                              data_v_i,
    output logic                              data_ready_and_o,

    output logic [flit_width_p-1:0]           link_data_o,
    output logic                              link_v_o,
    input  logic                              link_ready_and_i,
    output logic                              link_last_o
);

    localparam int hdr_width_lp     = hdr_len_p * flit_width_p;
    localparam int hdr_cnt_width_lp = $clog2(hdr_len_p + 1);

    localparam logic [1:0] e_ready = 2'd0;
    localparam logic [1:0] e_hdr   = 2'd1;
    localparam logic [1:0] e_data  = 2'd2;

    logic [1:0]                  state_r,    state_n;
    logic [hdr_width_lp-1:0]     hdr_r,      hdr_n;
    logic [hdr_cnt_width_lp-1:0] hdr_cnt_r,  hdr_cnt_n;
    logic [len_width_p-1:0]      data_cnt_r, data_cnt_n;

    logic [len_width_p-1:0]      hdr_len_field;
    logic [len_width_p-1:0]      data_cnt_init;
    logic                        hdr_accept;
    logic                        link_accept;

    assign hdr_len_field = hdr_i[cord_width_p +: len_width_p];
    // Modulo len_width_p: a header-only packet (len == hdr_len_p-1) yields 0.
    assign data_cnt_init = hdr_len_field - len_width_p'(hdr_len_p) + len_width_p'(1);

    assign hdr_accept  = hdr_v_i & hdr_ready_and_o;
    assign link_accept = link_v_o & link_ready_and_i;

    // Output decode: everything is a function of the registered state, except
    // the data passthrough in e_data (and header flit 0 in the bypass build).
    // Outputs are qualified with reset_n_i so the link goes quiet the instant
    // reset is asserted.
    always_comb begin
        hdr_ready_and_o  = 1'b0;
        data_ready_and_o = 1'b0;
        link_v_o         = 1'b0;
        link_data_o      = hdr_r[flit_width_p-1:0];
        link_last_o      = 1'b0;
        case (state_r)
            e_ready: begin
`ifdef BP_ME_WORMHOLE_TX_HDR_BYPASS_EN
                hdr_ready_and_o = reset_n_i & link_ready_and_i;
                link_v_o        = reset_n_i & hdr_v_i;
                link_data_o     = hdr_i[flit_width_p-1:0];
                link_last_o     = reset_n_i & (hdr_len_p == 1) & (data_cnt_init == '0);
`else
                hdr_ready_and_o = reset_n_i;
`endif
            end
            e_hdr: begin
                link_v_o    = 1'b1;
                link_last_o = (hdr_cnt_r == hdr_cnt_width_lp'(1)) & (data_cnt_r == '0);
            end
            e_data: begin
                link_v_o         = data_v_i;
                link_data_o      = data_i;
                data_ready_and_o = link_ready_and_i;
                link_last_o      = (data_cnt_r == len_width_p'(1));
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_n    = state_r;
        hdr_n      = hdr_r;
        hdr_cnt_n  = hdr_cnt_r;
        data_cnt_n = data_cnt_r;
        case (state_r)
            e_ready: begin
                if (hdr_accept) begin
                    data_cnt_n = data_cnt_init;
`ifdef BP_ME_WORMHOLE_TX_HDR_BYPASS_EN
                    // Flit 0 leaves this cycle; only the remainder is buffered.
                    hdr_n     = hdr_i >> flit_width_p;
                    hdr_cnt_n = hdr_cnt_width_lp'(hdr_len_p - 1);
                    if (hdr_len_p > 1) begin
                        state_n = e_hdr;
                    end else if (data_cnt_init != '0) begin
                        state_n = e_data;
                    end else begin
                        state_n = e_ready;
                    end
`else
                    hdr_n     = hdr_i;
                    hdr_cnt_n = hdr_cnt_width_lp'(hdr_len_p);
                    state_n   = e_hdr;
`endif
                end
            end
            e_hdr: begin
                if (link_accept) begin
                    hdr_n     = hdr_r >> flit_width_p;
                    hdr_cnt_n = hdr_cnt_r - hdr_cnt_width_lp'(1);
                    if (hdr_cnt_r == hdr_cnt_width_lp'(1)) begin
                        state_n = (data_cnt_r != '0) ? e_data : e_ready;
                    end
                end
            end
            e_data: begin
                if (link_accept) begin
                    data_cnt_n = data_cnt_r - len_width_p'(1);
                    if (data_cnt_r == len_width_p'(1)) begin
                        state_n = e_ready;
                    end
                end
            end
            default: begin
                state_n = e_ready;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_ready;
            hdr_r      <= '0;
            hdr_cnt_r  <= '0;
            data_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            hdr_r      <= hdr_n;
            hdr_cnt_r  <= hdr_cnt_n;
            data_cnt_r <= data_cnt_n;
        end
    end

`ifndef SYNTHESIS
    // A len shorter than the header would wrap data_cnt and stream garbage.
    len_covers_header_a : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        hdr_accept |-> (int'(hdr_len_field) >= hdr_len_p - 1)
    );
`endif

endmodule

// File: tb/tb_bp_me_wormhole_stream_tx.sv
`timescale 1ns/1ps
module tb_bp_me_wormhole_stream_tx;

    localparam int flit_width_p = 64;
    localparam int cord_width_p = 5;
    localparam int len_width_p  = 4;
    localparam int hdr_len_p    = 2;

`ifdef BP_ME_WORMHOLE_TX_HDR_BYPASS_EN
    localparam int exp_gap_lp = 1;
`else
    localparam int exp_gap_lp = 2;
`endif

    logic         clk_i            = 1'b0;
    logic         reset_n_i        = 1'b0;
    logic [127:0] hdr_i            = '0;
    logic         hdr_v_i          = 1'b0;
    logic         hdr_ready_and_o;
    logic [63:0]  data_i           = '0;
    logic         data_v_i         = 1'b0;
    logic         data_ready_and_o;
    logic [63:0]  link_data_o;
    logic         link_v_o;
    logic         link_ready_and_i = 1'b1;
    logic         link_last_o;

    bp_me_wormhole_stream_tx #(
        .flit_width_p(flit_width_p),
        .cord_width_p(cord_width_p),
        .len_width_p (len_width_p),
        .hdr_len_p   (hdr_len_p)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .hdr_i           (hdr_i),
        .hdr_v_i         (hdr_v_i),
        .hdr_ready_and_o (hdr_ready_and_o),
        .data_i          (data_i),
        .data_v_i        (data_v_i),
        .data_ready_and_o(data_ready_and_o),
        .link_data_o     (link_data_o),
        .link_v_o        (link_v_o),
        .link_ready_and_i(link_ready_and_i),
        .link_last_o     (link_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } flit_t;

    flit_t        exp_q[$];
    logic [127:0] hq[$];
    logic [63:0]  dq[$];
    int           acc_cyc[$];

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    acc_count   = 0;
    int    ready_mode  = 0;   // 0: always ready, 1: toggle 1010, 2: stalled
    bit    gap_en      = 1'b0;
    bit    watch_dready = 1'b0;
    int    dready_seen = 0;
    bit    hacc        = 1'b0;
    bit    dacc        = 1'b0;
    bit    stalled_prev = 1'b0;
    logic [63:0] stalled_data = '0;
    flit_t e_mon;

    task automatic check1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Queue one packet: header goes to the header driver, beats to the data
    // driver, and the hand-chosen flit sequence to the scoreboard. nbeats is
    // given explicitly by each test vector.
    task automatic push_packet(input logic [3:0] len, input logic [4:0] cord,
                               input logic [63:0] tag, input int nbeats,
                               input logic [63:0] beat_base);
        logic [63:0] h0;
        logic [63:0] h1;
        logic [63:0] d;
        h0 = {tag[63:9], len, cord};
        h1 = ~tag;
        hq.push_back({h1, h0});
        exp_q.push_back({h0, 1'b0});
        exp_q.push_back({h1, (nbeats == 0)});
        for (int i = 0; i < nbeats; i++) begin
            d = beat_base + 64'(i);
            dq.push_back(d);
            exp_q.push_back({d, (i == nbeats - 1)});
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hq.size() != 0 || dq.size() != 0) && n < limit) begin
            @(posedge clk_i);
            n++;
        end
        repeat (2) @(posedge clk_i);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d flits outstanding want 0", name, exp_q.size());
            exp_q.delete();
            hq.delete();
            dq.delete();
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Drivers: act 1ns after the edge, using handshakes sampled at the
    // preceding falling edge. Valids are held until accepted.
    always @(posedge clk_i) begin
        #1;
        if (hacc && hq.size() != 0) void'(hq.pop_front());
        if (hq.size() != 0) begin
            hdr_v_i = 1'b1;
            hdr_i   = hq[0];
        end else begin
            hdr_v_i = 1'b0;
        end

        if (dacc && dq.size() != 0) void'(dq.pop_front());
        if (dq.size() != 0 && ((data_v_i && !dacc) || !gap_en || (cyc % 3) != 0)) begin
            data_v_i = 1'b1;
            data_i   = dq[0];
        end else begin
            data_v_i = 1'b0;
        end

        case (ready_mode)
            0:       link_ready_and_i = 1'b1;
            1:       link_ready_and_i = ((cyc % 2) == 0);
            default: link_ready_and_i = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every flit handshake.
    always @(negedge clk_i) begin
        hacc = hdr_v_i & hdr_ready_and_o;
        dacc = data_v_i & data_ready_and_o;
        if (!reset_n_i) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check1("stall_valid_held", link_v_o, 1'b1);
                check64("stall_data_stable", link_data_o, stalled_data);
            end
            if (watch_dready && data_ready_and_o) dready_seen++;
            if (link_v_o && link_ready_and_i) begin
                acc_count++;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_flit: got %h want none", link_data_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    check64("flit_data", link_data_o, e_mon.data);
                    check1("flit_last", link_last_o, e_mon.last);
                end
            end
            stalled_prev = link_v_o & !link_ready_and_i;
            stalled_data = link_data_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk_i);
        #2;
        check1("rst_link_v", link_v_o, 1'b0);
        check1("rst_link_last", link_last_o, 1'b0);
        check1("rst_data_ready", data_ready_and_o, 1'b0);
        reset_n_i = 1'b1;
        #1;
        check1("post_rst_hdr_ready", hdr_ready_and_o, 1'b1);
        @(posedge clk_i);

        // 1: len=3 -> H0,H1,A,B, last on B
        push_packet(4'd3, 5'd7, 64'hA1A1_B2B2_C3C3_D4D4, 2, 64'h0000_00AA_0000_0000);
        wait_drain("t1", 50);

        // 2: header-only, len=1 -> H0,H1, last on H1, no data handshake
        watch_dready = 1'b1;
        push_packet(4'd1, 5'd3, 64'h1234_5678_9ABC_DEF0, 0, 64'h0);
        wait_drain("t2", 50);
        watch_dready = 1'b0;
        check_int("t2_data_ready_cycles", dready_seen, 0);

        // 3: len=5, link toggling and data gaps -> 4 beats in order
        ready_mode = 1;
        gap_en     = 1'b1;
        push_packet(4'd5, 5'd12, 64'hCAFE_F00D_0BAD_BEEF, 4, 64'h3333_0000_0000_0010);
        wait_drain("t3", 200);
        ready_mode = 0;
        gap_en     = 1'b0;
        repeat (2) @(posedge clk_i);

        // 4: back-to-back packets, idle-cycle count between them
        acc_cyc.delete();
        push_packet(4'd2, 5'd1, 64'h4444_5555_6666_7777, 1, 64'h4040_4040_4040_4040);
        push_packet(4'd1, 5'd2, 64'h8888_9999_AAAA_BBBB, 0, 64'h0);
        wait_drain("t4", 50);
        check_int("t4_flit_count", acc_cyc.size(), 5);
        if (acc_cyc.size() >= 4)
            check_int("t4_packet_gap", acc_cyc[3] - acc_cyc[2], exp_gap_lp);

        // 5: reset while the 2nd data flit of a len=5 packet is on the link
        base = acc_count;
        push_packet(4'd5, 5'd9, 64'h5A5A_5A5A_A5A5_A5A5, 4, 64'h5000_0000_0000_0000);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            #1;
            if (acc_count >= base + 3) seen = 1'b1;
        end
        check1("t5_reached_d0", seen, 1'b1);
        ready_mode = 2;
        @(posedge clk_i);
        #3;
        check1("t5_d1_valid", link_v_o, 1'b1);
        check64("t5_d1_data", link_data_o, 64'h5000_0000_0000_0001);
        reset_n_i = 1'b0;
        #1;
        check1("t5_rst_link_v", link_v_o, 1'b0);
        check1("t5_rst_data_ready", data_ready_and_o, 1'b0);
        check1("t5_rst_link_last", link_last_o, 1'b0);
        exp_q.delete();
        hq.delete();
        dq.delete();
        repeat (2) @(posedge clk_i);
        #3;
        reset_n_i  = 1'b1;
        ready_mode = 0;
        @(posedge clk_i);
        push_packet(4'd3, 5'd4, 64'h6060_7070_8080_9090, 2, 64'h6000_0000_0000_00E0);
        wait_drain("t5_post", 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
